// File: rtl/exec_sequencer.sv
// Execute-stage controller: drives ALUControl, sequences fixed-latency MUL/MOD,
// owns the Z/N compare flags and resolves JMP/JEQ/JGT for writeback.
module exec_sequencer #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned MOD_CYCLES = 16,
   parameter int unsigned CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] opcode,
   input  logic       flush,
   input  logic       alu_zero,
   input  logic       alu_neg,
   input  logic       out_ready,
   output logic [2:0] alu_ctrl,
   output logic       mc_start,
   output logic       mc_busy,
   output logic       out_valid,
   output logic       wb_en,
   output logic       branch_taken,
   output logic       illegal_op
);

   localparam logic [4:0] OP_ADD  = 5'b11000;
   localparam logic [4:0] OP_SUB  = 5'b11010;
   localparam logic [4:0] OP_MUL  = 5'b11110;
   localparam logic [4:0] OP_MOD  = 5'b11100;
   localparam logic [4:0] OP_LSR  = 5'b11001;
   localparam logic [4:0] OP_MOVR = 5'b10100;
   localparam logic [4:0] OP_MOVI = 5'b10101;
   localparam logic [4:0] OP_CMPR = 5'b10110;
   localparam logic [4:0] OP_CMPI = 5'b10111;
   localparam logic [4:0] OP_JMP  = 5'b00001;
   localparam logic [4:0] OP_JEQ  = 5'b00111;
   localparam logic [4:0] OP_JGT  = 5'b00011;

   localparam logic [2:0] CTRL_IDLE = 3'b111;

   // Counter is loaded with L-1 so RESULT is entered exactly L cycles after accept.
   localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] MOD_RELOAD = CNT_W'(MOD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULTI  = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [4:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic             flag_z;
   logic             flag_n;

   logic [2:0]       dec_ctrl;
   logic             dec_multi;
   logic [CNT_W-1:0] dec_reload;
   logic             q_wb;
   logic             q_cmp;
   logic             q_taken;
   logic             q_illegal;
   logic             accept;
   logic             handoff;

   assign accept  = in_valid && in_ready;
   assign handoff = (state == RESULT) && out_ready && !flush;

   // Decode of the incoming opcode: ALU control and execute latency.
   always_comb begin
      dec_ctrl   = CTRL_IDLE;
      dec_multi  = 1'b0;
      dec_reload = '0;
      case (opcode)
         OP_ADD:                 dec_ctrl = 3'b000;
         OP_SUB:                 dec_ctrl = 3'b001;
         OP_MUL: begin
            dec_ctrl   = 3'b010;
            dec_multi  = 1'b1;
            dec_reload = MUL_RELOAD;
         end
         OP_MOD: begin
            dec_ctrl   = 3'b011;
            dec_multi  = 1'b1;
            dec_reload = MOD_RELOAD;
         end
         OP_LSR:                 dec_ctrl = 3'b100;
         OP_MOVR:                dec_ctrl = 3'b111;
         OP_MOVI:                dec_ctrl = 3'b101;
         OP_CMPR, OP_CMPI:       dec_ctrl = 3'b001;
         OP_JMP, OP_JEQ, OP_JGT: dec_ctrl = 3'b000;
         default:                dec_ctrl = CTRL_IDLE;
      endcase
   end

   // Decode of the held opcode: writeback, flag write and branch resolution.
   always_comb begin
      q_wb      = 1'b0;
      q_cmp     = 1'b0;
      q_taken   = 1'b0;
      q_illegal = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB, OP_MUL, OP_MOD,
         OP_LSR, OP_MOVR, OP_MOVI:        q_wb = 1'b1;
         OP_CMPR, OP_CMPI:                q_cmp = 1'b1;
         OP_JMP:                          q_taken = 1'b1;
         OP_JEQ:                          q_taken = flag_z;
         OP_JGT:                          q_taken = !flag_z && !flag_n;
         default:                         q_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = dec_multi ? MULTI : RESULT;
            MULTI:   if (cnt == CNT_ONE) state_nxt = RESULT;
            RESULT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready     = (state == IDLE) && !flush;
      mc_busy      = (state == MULTI);
      out_valid    = (state == RESULT);
      wb_en        = (state == RESULT) && q_wb;
      branch_taken = (state == RESULT) && q_taken;
      illegal_op   = (state == RESULT) && q_illegal;
   end

   // Opcode latch, ALU control, latency counter, start pulse and flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         alu_ctrl <= CTRL_IDLE;
         cnt      <= '0;
         mc_start <= 1'b0;
         flag_z   <= 1'b0;
         flag_n   <= 1'b0;
      end else if (flush) begin
         alu_ctrl <= CTRL_IDLE;
         cnt      <= '0;
         mc_start <= 1'b0;
      end else if (accept) begin
         op_q     <= opcode;
         alu_ctrl <= dec_ctrl;
         cnt      <= dec_reload;
         mc_start <= dec_multi;
      end else begin
         mc_start <= 1'b0;
         if (state == MULTI && cnt != CNT_ONE) cnt <= cnt - CNT_ONE;
         else if (state == MULTI)              cnt <= '0;
         if (handoff) begin
            alu_ctrl <= CTRL_IDLE;
            if (q_cmp) begin
               flag_z <= alu_zero;
               flag_n <= alu_neg;
            end
         end
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an age-based transaction model.
module tb_exec_sequencer;
   localparam int unsigned MUL_CYCLES = 4;
   localparam int unsigned MOD_CYCLES = 16;
   localparam int unsigned CNT_W      = 5;

   localparam logic [4:0] ADD = 5'b11000, SUB = 5'b11010, MUL = 5'b11110, MOD = 5'b11100;
   localparam logic [4:0] LSR = 5'b11001, MOVR = 5'b10100, MOVI = 5'b10101;
   localparam logic [4:0] CMPR = 5'b10110, CMPI = 5'b10111;
   localparam logic [4:0] JMP = 5'b00001, JEQ = 5'b00111, JGT = 5'b00011;
   localparam logic [4:0] KNOWN [12] = '{ADD, SUB, MUL, MOD, LSR, MOVR, MOVI, CMPR, CMPI, JMP, JEQ, JGT};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0, flush = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0, out_ready = 1'b0;
   logic [4:0] opcode = '0;
   logic       in_ready, mc_start, mc_busy, out_valid, wb_en, branch_taken, illegal_op;
   logic [2:0] alu_ctrl;

   exec_sequencer #(.MUL_CYCLES(MUL_CYCLES), .MOD_CYCLES(MOD_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .flush(flush), .alu_zero(alu_zero), .alu_neg(alu_neg), .out_ready(out_ready),
      .alu_ctrl(alu_ctrl), .mc_start(mc_start), .mc_busy(mc_busy), .out_valid(out_valid),
      .wb_en(wb_en), .branch_taken(branch_taken), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Transaction model: one op in flight, its age in cycles since the accept edge.
   bit         m_inflight = 1'b0;
   logic [4:0] m_op = '0;
   int         m_age = 0;
   bit         m_z = 1'b0, m_n = 1'b0;

   logic [2:0] s_ctrl;
   logic       s_ready, s_start, s_busy, s_valid, s_wb, s_taken, s_ill;

   function automatic int m_lat(input logic [4:0] op);
      if (op == MUL) return int'(MUL_CYCLES);
      if (op == MOD) return int'(MOD_CYCLES);
      return 1;
   endfunction

   function automatic bit m_known(input logic [4:0] op);
      for (int i = 0; i < 12; i++) if (KNOWN[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] m_ctrl(input logic [4:0] op);
      case (op)
         ADD: return 3'b000;  SUB: return 3'b001;  MUL: return 3'b010;  MOD: return 3'b011;
         LSR: return 3'b100;  MOVR: return 3'b111; MOVI: return 3'b101;
         CMPR, CMPI: return 3'b001;
         JMP, JEQ, JGT: return 3'b000;
         default: return 3'b111;
      endcase
   endfunction

   function automatic bit m_wb(input logic [4:0] op);
      return (op == ADD || op == SUB || op == MUL || op == MOD || op == LSR || op == MOVR || op == MOVI);
   endfunction

   function automatic bit m_taken(input logic [4:0] op, input bit z, input bit n);
      if (op == JMP) return 1'b1;
      if (op == JEQ) return z;
      if (op == JGT) return !z && !n;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
      end
   endtask

   // One clock: drive inputs at negedge, compare against the model, advance the model at posedge.
   task automatic cycle(input bit r, input bit iv, input logic [4:0] op, input bit fl,
                        input bit z, input bit n, input bit ordy);
      int L;
      bit e_valid, e_busy, e_start, e_ready;
      logic [2:0] e_ctrl;
      @(negedge clk);
      rst = r; in_valid = iv; opcode = op; flush = fl; alu_zero = z; alu_neg = n; out_ready = ordy;
      #1;
      if (r) begin m_inflight = 1'b0; m_z = 1'b0; m_n = 1'b0; end
      L       = m_lat(m_op);
      e_valid = m_inflight && m_age >= L;
      e_busy  = m_inflight && m_age < L;
      e_start = e_busy && m_age == 1;
      e_ready = !m_inflight && !fl;
      e_ctrl  = m_inflight ? m_ctrl(m_op) : 3'b111;
      s_ctrl = alu_ctrl; s_ready = in_ready; s_start = mc_start; s_busy = mc_busy;
      s_valid = out_valid; s_wb = wb_en; s_taken = branch_taken; s_ill = illegal_op;
      chk("alu_ctrl", s_ctrl, e_ctrl);
      chk("in_ready", 3'(s_ready), 3'(e_ready));
      chk("mc_start", 3'(s_start), 3'(e_start));
      chk("mc_busy", 3'(s_busy), 3'(e_busy));
      chk("out_valid", 3'(s_valid), 3'(e_valid));
      chk("wb_en", 3'(s_wb), 3'(e_valid && m_wb(m_op)));
      chk("branch_taken", 3'(s_taken), 3'(e_valid && m_taken(m_op, m_z, m_n)));
      chk("illegal_op", 3'(s_ill), 3'(e_valid && !m_known(m_op)));
      @(posedge clk);
      if (r) begin
         m_inflight = 1'b0;
      end else if (fl) begin
         m_inflight = 1'b0;
      end else if (!m_inflight) begin
         if (iv) begin m_inflight = 1'b1; m_op = op; m_age = 1; end
      end else if (m_age >= L) begin
         if (ordy) begin
            if (m_op == CMPR || m_op == CMPI) begin m_z = z; m_n = n; end
            m_inflight = 1'b0;
         end
      end else begin
         m_age++;
      end
      cyc++;
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, ordy);
   endtask

   task automatic issue(input logic [4:0] op);
      cycle(1'b0, 1'b1, op, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [4:0] rop;
      cycle(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lit_rst_ctrl", s_ctrl, 3'b111);
      chk("lit_rst_ready", 3'(s_ready), 3'd1);
      chk("lit_rst_valid", 3'(s_valid), 3'd0);

      // single-cycle ADD
      issue(ADD);
      idle(1'b1);
      chk("lit_add_valid", 3'(s_valid), 3'd1);
      chk("lit_add_ctrl", s_ctrl, 3'b000);
      chk("lit_add_wb", 3'(s_wb), 3'd1);
      idle(1'b1);
      chk("lit_add_ctrl_idle", s_ctrl, 3'b111);
      chk("lit_add_ready", 3'(s_ready), 3'd1);

      // MUL latency
      issue(MUL);
      idle(1'b1); chk("lit_mul_start1", 3'(s_start), 3'd1); chk("lit_mul_busy1", 3'(s_busy), 3'd1);
      idle(1'b1); chk("lit_mul_start2", 3'(s_start), 3'd0);
      idle(1'b1); chk("lit_mul_valid3", 3'(s_valid), 3'd0); chk("lit_mul_busy3", 3'(s_busy), 3'd1);
      idle(1'b1); chk("lit_mul_valid4", 3'(s_valid), 3'd1); chk("lit_mul_ctrl4", s_ctrl, 3'b010);
      idle(1'b1); chk("lit_mul_ctrl5", s_ctrl, 3'b111);

      // compare then branch
      issue(CMPR);
      cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b1); chk("lit_cmp_wb", 3'(s_wb), 3'd0);
      issue(JEQ);
      idle(1'b1); chk("lit_jeq_taken", 3'(s_taken), 3'd1); chk("lit_jeq_wb", 3'(s_wb), 3'd0);
      issue(CMPR);
      cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      issue(JGT);
      idle(1'b1); chk("lit_jgt_taken", 3'(s_taken), 3'd0);
      issue(JMP);
      idle(1'b1); chk("lit_jmp_taken", 3'(s_taken), 3'd1);

      // flush in the 5th MULTI cycle of MOD
      issue(MOD);
      repeat (4) idle(1'b1);
      cycle(1'b0, 1'b0, 5'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("lit_flush_ready", 3'(s_ready), 3'd0); chk("lit_flush_busy", 3'(s_busy), 3'd1);
      idle(1'b1);
      chk("lit_flush_valid", 3'(s_valid), 3'd0); chk("lit_flush_ready_after", 3'(s_ready), 3'd1);
      chk("lit_flush_ctrl", s_ctrl, 3'b111);
      // flushed CMPR in RESULT must not write flags (Z stays 0)
      issue(CMPR);
      cycle(1'b0, 1'b0, 5'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      issue(JEQ);
      idle(1'b1); chk("lit_flush_noflag", 3'(s_taken), 3'd0);

      // stall in RESULT with new requests pending
      issue(ADD);
      repeat (3) begin
         cycle(1'b0, 1'b1, SUB, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("lit_stall_valid", 3'(s_valid), 3'd1); chk("lit_stall_ctrl", s_ctrl, 3'b000);
         chk("lit_stall_ready", 3'(s_ready), 3'd0);
      end
      idle(1'b1);
      idle(1'b1); chk("lit_stall_done", s_ctrl, 3'b111); chk("lit_stall_novalid", 3'(s_valid), 3'd0);

      // unknown opcode
      issue(5'b01010);
      idle(1'b1);
      chk("lit_ill_valid", 3'(s_valid), 3'd1); chk("lit_ill_flag", 3'(s_ill), 3'd1);
      chk("lit_ill_wb", 3'(s_wb), 3'd0); chk("lit_ill_ctrl", s_ctrl, 3'b111);

      // reset mid-MULTI also clears flags
      issue(CMPR);
      cycle(1'b0, 1'b0, 5'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      issue(MOD);
      repeat (3) idle(1'b1);
      cycle(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lit_rst_mid_ctrl", s_ctrl, 3'b111); chk("lit_rst_mid_busy", 3'(s_busy), 3'd0);
      chk("lit_rst_mid_ready", 3'(s_ready), 3'd1);
      issue(JEQ);
      idle(1'b1); chk("lit_rst_mid_flags", 3'(s_taken), 3'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) rop = 5'($urandom);
         else rop = KNOWN[$urandom_range(0, 11)];
         cycle($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rop,
               $urandom_range(0, 24) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
